// File: rtl/ifu_prefetch_queue.sv
// Instruction-fetch front end with a prefetch queue.
//
// Generates sequential word-aligned fetch addresses and issues them to instruction memory over a
// valid/ready request channel. At most one request is outstanding at a time. Returned words are
// tagged with their PC and buffered in a DEPTH-entry FIFO that feeds decode through a valid/ready
// handshake. A redirect flushes the FIFO, withdraws any unaccepted request, drops any in-flight
// response and restarts fetch at the new PC.
//
// Ports:
//   clock, reset           - clock; synchronous active-high reset
//   imem_req_valid/addr    - fetch request (addr is word aligned)
//   imem_req_ready         - memory accepts the request this cycle
//   imem_rsp_valid/data    - memory response, one per accepted request
//   redirect_valid/pc      - flush and restart fetch at redirect_pc (bits [1:0] ignored)
//   instr_valid/data/pc    - FIFO head presented to decode
//   instr_ready            - decode consumes the head this cycle
//   queue_count            - occupied FIFO entries, 0..DEPTH
module ifu_prefetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                     clock,
   input  logic                     reset,
   output logic                     imem_req_valid,
   output logic [31:0]              imem_req_addr,
   input  logic                     imem_req_ready,
   input  logic                     imem_rsp_valid,
   input  logic [31:0]              imem_rsp_data,
   input  logic                     redirect_valid,
   input  logic [31:0]              redirect_pc,
   output logic                     instr_valid,
   output logic [31:0]              instr_data,
   output logic [31:0]              instr_pc,
   input  logic                     instr_ready,
   output logic [$clog2(DEPTH):0]   queue_count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StDrop
   } state_e;

   state_e        state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   req_pc_q, req_pc_d;
   logic [PW-1:0] rd_ptr_q, wr_ptr_q;
   logic [CW-1:0] count_q;
   logic [31:0]   data_mem_q [DEPTH];
   logic [31:0]   pc_mem_q   [DEPTH];

   logic req_fire;
   logic push;
   logic pop;

   // Redirect always realigns to a word boundary; the low bits carry no information.
   logic unused_redirect_lsb;
   assign unused_redirect_lsb = ^redirect_pc[1:0];

   always_comb begin
      // Credit comes from the registered count only, so a response always finds a free entry.
      imem_req_valid = !reset && (state_q == StIdle) && (count_q < DepthCnt) && !redirect_valid;
      imem_req_addr  = fetch_pc_q;
      req_fire       = imem_req_valid && imem_req_ready;

      instr_valid    = (count_q != '0);
      instr_data     = data_mem_q[rd_ptr_q];
      instr_pc       = pc_mem_q[rd_ptr_q];
      queue_count    = count_q;

      // Redirect discards any same-cycle push or pop.
      push           = (state_q == StWait) && imem_rsp_valid && !redirect_valid;
      pop            = instr_valid && instr_ready && !redirect_valid;
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;

      case (state_q)
         StIdle: begin
            if (req_fire) begin
               state_d  = StWait;
               req_pc_d = fetch_pc_q;
            end
         end
         StWait: begin
            // A response in the redirect cycle is consumed here and simply not pushed.
            if (imem_rsp_valid) begin
               state_d = StIdle;
            end else if (redirect_valid) begin
               state_d = StDrop;
            end
         end
         StDrop: begin
            if (imem_rsp_valid) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
      end else if (req_fire) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= StIdle;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            data_mem_q[i] <= '0;
            pc_mem_q[i]   <= '0;
         end
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         if (redirect_valid) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            if (push) begin
               data_mem_q[wr_ptr_q] <= imem_rsp_data;
               pc_mem_q[wr_ptr_q]   <= req_pc_q;
               wr_ptr_q             <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
               rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
               2'b10:   count_q <= count_q + CW'(1);
               2'b01:   count_q <= count_q - CW'(1);
               default: count_q <= count_q;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ifu_prefetch_queue.sv
// Self-checking bench for ifu_prefetch_queue: directed scenarios plus a randomized run checked
// against a queue-based reference model of the fetch front end and a variable-latency memory.
module tb_ifu_prefetch_queue;

   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int unsigned CW       = $clog2(DEPTH) + 1;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          imem_req_valid;
   logic [31:0]   imem_req_addr;
   logic          imem_req_ready = 1'b0;
   logic          imem_rsp_valid = 1'b0;
   logic [31:0]   imem_rsp_data = '0;
   logic          redirect_valid = 1'b0;
   logic [31:0]   redirect_pc = '0;
   logic          instr_valid;
   logic [31:0]   instr_data;
   logic [31:0]   instr_pc;
   logic          instr_ready = 1'b0;
   logic [CW-1:0] queue_count;

   ifu_prefetch_queue #(
      .DEPTH   (DEPTH),
      .RESET_PC(RESET_PC)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .imem_req_valid(imem_req_valid),
      .imem_req_addr (imem_req_addr),
      .imem_req_ready(imem_req_ready),
      .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data (imem_rsp_data),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .instr_valid   (instr_valid),
      .instr_data    (instr_data),
      .instr_pc      (instr_pc),
      .instr_ready   (instr_ready),
      .queue_count   (queue_count)
   );

   always #5 clock = ~clock;

   int n_total = 0;
   int n_pass  = 0;

   // Reference model: queued {pc, data} pairs, next fetch PC, one outstanding request.
   logic [63:0]   mq[$];
   logic [31:0]   m_fetch = RESET_PC;
   logic [31:0]   m_req_pc = '0;
   bit            m_out = 0;
   bit            m_drop = 0;
   logic          exp_req_valid;
   logic [CW-1:0] exp_count;
   logic [63:0]   exp_head;

   // Memory model.
   bit            mem_pending = 0;
   int            mem_delay = 0;
   int            mem_lat = 1;
   logic [31:0]   mem_addr = '0;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      if (a == 32'h0) return 32'h0094_0333;
      if (a == 32'h4) return 32'h4093_03B3;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   // Drive the memory response for this cycle and compute expected outputs.
   task automatic settle();
      imem_rsp_valid = mem_pending && (mem_delay == 0);
      imem_rsp_data  = imem_rsp_valid ? word_of(mem_addr) : $urandom;
      #1;
      exp_req_valid = !reset && !m_out && (mq.size() < DEPTH) && !redirect_valid;
      exp_count     = CW'(mq.size());
      exp_head      = (mq.size() != 0) ? mq[0] : 64'h0;
   endtask

   // Advance one clock edge, updating the reference model and the memory model.
   task automatic commit();
      bit          dut_acc;
      bit          m_acc;
      logic [31:0] acc_addr;
      dut_acc  = imem_req_valid && imem_req_ready;
      acc_addr = imem_req_addr;
      m_acc    = exp_req_valid && imem_req_ready;
      @(posedge clock);
      if (reset) begin
         mq.delete();
         m_fetch = RESET_PC;
         m_out   = 0;
         m_drop  = 0;
      end else if (redirect_valid) begin
         mq.delete();
         m_fetch = {redirect_pc[31:2], 2'b00};
         if (m_out) begin
            if (imem_rsp_valid) begin
               m_out  = 0;
               m_drop = 0;
            end else begin
               m_drop = 1;
            end
         end
      end else begin
         if (mq.size() != 0 && instr_ready) void'(mq.pop_front());
         if (m_out && imem_rsp_valid) begin
            if (!m_drop) mq.push_back({m_req_pc, imem_rsp_data});
            m_out  = 0;
            m_drop = 0;
         end
         if (m_acc) begin
            m_req_pc = m_fetch;
            m_fetch  = m_fetch + 32'd4;
            m_out    = 1;
         end
      end
      if (imem_rsp_valid) mem_pending = 0;
      else if (mem_pending && mem_delay != 0) mem_delay--;
      if (dut_acc) begin
         mem_pending = 1;
         mem_addr    = acc_addr;
         mem_delay   = mem_lat - 1;
      end
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      redirect_valid = 1'b0;
      repeat (4) begin
         settle();
         commit();
      end
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset          = 1'b1;
      imem_req_ready = 1'b1;
      instr_ready    = 1'b0;
      for (int c = 0; c < 2; c++) begin
         settle();
         n_total++;
         if (imem_req_valid !== 1'b0)
            $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid);
         else n_pass++;
         commit();
      end
      reset          = 1'b0;
      imem_req_ready = 1'b0;
      settle();
      n_total++;
      if ({instr_valid, instr_data, instr_pc} !== 65'h0)
         $display("FAIL reset_outputs: got v=%b d=%h pc=%h expected 0 0 0",
                  instr_valid, instr_data, instr_pc);
      else n_pass++;
      n_total++;
      if (queue_count !== CW'(0))
         $display("FAIL reset_count: got %0d expected 0", queue_count);
      else n_pass++;
      n_total++;
      if ({imem_req_valid, imem_req_addr} !== {1'b1, RESET_PC})
         $display("FAIL reset_first_req: got v=%b a=%h expected 1 %h",
                  imem_req_valid, imem_req_addr, RESET_PC);
      else n_pass++;
      commit();
   endtask

   task automatic test_fetch_basic();
      mem_lat        = 1;
      imem_req_ready = 1'b1;
      instr_ready    = 1'b1;
      for (int c = 0; c < 6; c++) begin
         settle();
         n_total++;
         if ((c % 2 == 0) && {imem_req_valid, imem_req_addr} !== {1'b1, 32'(c * 2)})
            $display("FAIL basic_req c%0d: got v=%b a=%h expected 1 %h",
                     c, imem_req_valid, imem_req_addr, 32'(c * 2));
         else if ((c % 2 == 1) && imem_req_valid !== 1'b0)
            $display("FAIL basic_req c%0d: got v=%b expected 0", c, imem_req_valid);
         else n_pass++;
         if (c == 1 || c == 3) begin
            n_total++;
            if (instr_valid !== 1'b0)
               $display("FAIL basic_latency c%0d: got %b expected 0", c, instr_valid);
            else n_pass++;
         end
         if (c == 2) begin
            n_total++;
            if ({instr_valid, instr_pc, instr_data} !== {1'b1, 32'h0, 32'h0094_0333})
               $display("FAIL basic_head0: got %b %h %h expected 1 0 00940333",
                        instr_valid, instr_pc, instr_data);
            else n_pass++;
         end
         if (c == 4) begin
            n_total++;
            if ({instr_valid, instr_pc, instr_data} !== {1'b1, 32'h4, 32'h4093_03B3})
               $display("FAIL basic_head1: got %b %h %h expected 1 4 409303b3",
                        instr_valid, instr_pc, instr_data);
            else n_pass++;
         end
         commit();
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] addrs[$];
      mem_lat        = 1;
      imem_req_ready = 1'b1;
      do_reset();
      instr_ready = 1'b0;
      for (int c = 0; c < 12; c++) begin
         settle();
         if (imem_req_valid && imem_req_ready) addrs.push_back(imem_req_addr);
         commit();
      end
      settle();
      n_total++;
      if (addrs.size() != 4)
         $display("FAIL bp_req_count: got %0d expected 4", addrs.size());
      else n_pass++;
      for (int i = 0; i < addrs.size() && i < 4; i++) begin
         n_total++;
         if (addrs[i] !== 32'(4 * i))
            $display("FAIL bp_req_addr%0d: got %h expected %h", i, addrs[i], 32'(4 * i));
         else n_pass++;
      end
      n_total++;
      if ({queue_count, imem_req_valid} !== {CW'(4), 1'b0})
         $display("FAIL bp_full: got count=%0d v=%b expected 4 0", queue_count, imem_req_valid);
      else n_pass++;
      instr_ready = 1'b1;
      commit();
      instr_ready = 1'b0;
      settle();
      n_total++;
      if ({queue_count, imem_req_valid, imem_req_addr} !== {CW'(3), 1'b1, 32'h10})
         $display("FAIL bp_after_pop: got count=%0d v=%b a=%h expected 3 1 00000010",
                  queue_count, imem_req_valid, imem_req_addr);
      else n_pass++;
      commit();
   endtask

   task automatic test_redirect_wait();
      mem_lat        = 4;
      imem_req_ready = 1'b1;
      do_reset();
      instr_ready = 1'b0;
      settle();
      commit();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h41;
      settle();
      n_total++;
      if (imem_req_valid !== 1'b0)
         $display("FAIL rw_redirect_req: got %b expected 0", imem_req_valid);
      else n_pass++;
      commit();
      redirect_valid = 1'b0;
      for (int c = 2; c < 5; c++) begin
         settle();
         n_total++;
         if ({imem_req_valid, instr_valid} !== 2'b00)
            $display("FAIL rw_drop c%0d: got v=%b iv=%b expected 0 0",
                     c, imem_req_valid, instr_valid);
         else n_pass++;
         commit();
      end
      mem_lat = 1;
      settle();
      n_total++;
      if ({imem_req_valid, imem_req_addr, queue_count} !== {1'b1, 32'h40, CW'(0)})
         $display("FAIL rw_new_req: got v=%b a=%h count=%0d expected 1 00000040 0",
                  imem_req_valid, imem_req_addr, queue_count);
      else n_pass++;
      commit();
      settle();
      commit();
      settle();
      n_total++;
      if ({instr_valid, instr_pc, instr_data} !== {1'b1, 32'h40, word_of(32'h40)})
         $display("FAIL rw_first_instr: got %b %h %h expected 1 00000040 %h",
                  instr_valid, instr_pc, instr_data, word_of(32'h40));
      else n_pass++;
      commit();
   endtask

   task automatic test_stall();
      mem_lat        = 1;
      imem_req_ready = 1'b1;
      do_reset();
      instr_ready = 1'b1;
      repeat (4) begin
         settle();
         commit();
      end
      imem_req_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         settle();
         n_total++;
         if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h8})
            $display("FAIL stall_hold c%0d: got v=%b a=%h expected 1 00000008",
                     c, imem_req_valid, imem_req_addr);
         else n_pass++;
         commit();
      end
      imem_req_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      settle();
      n_total++;
      if (imem_req_valid !== 1'b0)
         $display("FAIL stall_withdraw: got %b expected 0", imem_req_valid);
      else n_pass++;
      commit();
      redirect_valid = 1'b0;
      settle();
      n_total++;
      if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h100})
         $display("FAIL stall_new_addr: got v=%b a=%h expected 1 00000100",
                  imem_req_valid, imem_req_addr);
      else n_pass++;
      commit();
      settle();
      commit();
   endtask

   task automatic test_push_pop_redirect();
      mem_lat        = 1;
      imem_req_ready = 1'b1;
      do_reset();
      instr_ready = 1'b0;
      repeat (5) begin
         settle();
         commit();
      end
      instr_ready    = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      settle();
      n_total++;
      if ({queue_count, imem_rsp_valid} !== {CW'(2), 1'b1})
         $display("FAIL ppr_setup: got count=%0d rsp=%b expected 2 1", queue_count, imem_rsp_valid);
      else n_pass++;
      commit();
      redirect_valid = 1'b0;
      instr_ready    = 1'b0;
      settle();
      n_total++;
      if ({queue_count, instr_valid} !== {CW'(0), 1'b0})
         $display("FAIL ppr_flush: got count=%0d iv=%b expected 0 0", queue_count, instr_valid);
      else n_pass++;
      commit();
      settle();
      commit();
      settle();
      n_total++;
      if ({queue_count, instr_pc} !== {CW'(1), 32'h200})
         $display("FAIL ppr_no_stale: got count=%0d pc=%h expected 1 00000200",
                  queue_count, instr_pc);
      else n_pass++;
      commit();
   endtask

   task automatic test_reset_in_wait();
      mem_lat        = 1;
      imem_req_ready = 1'b1;
      do_reset();
      instr_ready = 1'b0;
      repeat (4) begin
         settle();
         commit();
      end
      mem_lat = 2;
      settle();
      commit();
      settle();
      commit();
      reset = 1'b1;
      settle();
      n_total++;
      if ({imem_req_valid, imem_rsp_valid, queue_count} !== {1'b0, 1'b1, CW'(2)})
         $display("FAIL riw_during: got v=%b rsp=%b count=%0d expected 0 1 2",
                  imem_req_valid, imem_rsp_valid, queue_count);
      else n_pass++;
      commit();
      reset   = 1'b0;
      mem_lat = 1;
      settle();
      n_total++;
      if ({queue_count, instr_valid, imem_req_valid, imem_req_addr} !==
          {CW'(0), 1'b0, 1'b1, RESET_PC})
         $display("FAIL riw_after: got count=%0d iv=%b v=%b a=%h expected 0 0 1 %h",
                  queue_count, instr_valid, imem_req_valid, imem_req_addr, RESET_PC);
      else n_pass++;
      commit();
   endtask

   task automatic test_wrap();
      mem_lat        = 1;
      imem_req_ready = 1'b1;
      instr_ready    = 1'b1;
      do_reset();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFB;
      settle();
      commit();
      redirect_valid = 1'b0;
      for (int c = 0; c < 6; c++) begin
         settle();
         if (c % 2 == 0) begin
            n_total++;
            if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'hFFFF_FFF8 + 32'(c * 2)})
               $display("FAIL wrap_addr c%0d: got v=%b a=%h expected 1 %h",
                        c, imem_req_valid, imem_req_addr, 32'hFFFF_FFF8 + 32'(c * 2));
            else n_pass++;
         end
         commit();
      end
   endtask

   task automatic test_random();
      mem_lat = 1;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         imem_req_ready = ($urandom_range(3, 0) != 0);
         instr_ready    = ($urandom_range(1, 0) != 0);
         redirect_valid = ($urandom_range(19, 0) == 0);
         redirect_pc    = $urandom;
         settle();
         n_total++;
         if (imem_req_valid !== exp_req_valid ||
             (exp_req_valid && imem_req_addr !== m_fetch))
            $display("FAIL rand_req c%0d: got v=%b a=%h expected %b %h",
                     c, imem_req_valid, imem_req_addr, exp_req_valid, m_fetch);
         else n_pass++;
         n_total++;
         if (queue_count !== exp_count || instr_valid !== (exp_count != 0))
            $display("FAIL rand_count c%0d: got count=%0d iv=%b expected %0d",
                     c, queue_count, instr_valid, exp_count);
         else n_pass++;
         if (exp_count != 0) begin
            n_total++;
            if ({instr_pc, instr_data} !== exp_head)
               $display("FAIL rand_head c%0d: got %h %h expected %h",
                        c, instr_pc, instr_data, exp_head);
            else n_pass++;
         end
         mem_lat = $urandom_range(4, 1);
         commit();
      end
      redirect_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fetch_basic();
      test_backpressure();
      test_redirect_wait();
      test_stall();
      test_push_pop_redirect();
      test_reset_in_wait();
      test_wrap();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
